// File: rtl/divider16_seq.sv
// Iterative restoring divider: one subtract-and-shift step per clock, WIDTH steps per operation.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module divider16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             DIV_BY_ZERO
);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] prem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] prem_d, quo_d;

`ifdef DIVIDER_SIGNED_EN
  logic qneg_q, rneg_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m, input logic neg);
    return neg ? (~m + WIDTH'(1)) : m;
  endfunction
`endif

  // The shifted-out top bit joins the partial remainder, so the trial needs WIDTH+1 bits.
  always_comb begin
    trial = {prem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      prem_d = trial[WIDTH-1:0];
      quo_d  = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      prem_d = {prem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_d  = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            if (DIVISOR == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
              quot_q  <= '1;
              rem_q   <= DIVIDEND;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              prem_q  <= '0;
`ifdef DIVIDER_SIGNED_EN
              quo_q   <= mag(DIVIDEND);
              dvs_q   <= mag(DIVISOR);
              qneg_q  <= DIVIDEND[WIDTH-1] ^ DIVISOR[WIDTH-1];
              rneg_q  <= DIVIDEND[WIDTH-1];
`else
              quo_q   <= DIVIDEND;
              dvs_q   <= DIVISOR;
`endif
            end
          end
        end
        CALC: begin
          prem_q <= prem_d;
          quo_q  <= quo_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            state_q <= FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            quot_q  <= apply_sign(quo_d, qneg_q);
            rem_q   <= apply_sign(prem_d, rneg_q);
`else
            quot_q  <= quo_d;
            rem_q   <= prem_d;
`endif
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign QUOTIENT    = quot_q;
  assign REMAINDER   = rem_q;
  assign DIV_BY_ZERO = dbz_q;
endmodule

// File: tb/tb_divider16_seq.sv
// Scoreboard bench for divider16_seq: stimulus pushes expected results, a monitor checks DONE and held outputs.
// Signed expectations are used when DIVIDER_SIGNED_EN is defined.
module tb_divider16_seq;
  localparam int W = 16;

  logic         CLK, RST, START;
  logic [W-1:0] DIVIDEND, DIVISOR;
  logic         BUSY, DONE, DIV_BY_ZERO;
  logic [W-1:0] QUOTIENT, REMAINDER;

  divider16_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
    .BUSY(BUSY), .DONE(DONE),
    .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER),
    .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    logic         nz;
    int           k;
  } exp_t;

  exp_t         sb[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  logic         rst_at_edge = 1'b0;
  logic         mon_en = 1'b0;
  logic         chk_busy = 1'b1;
  logic [W-1:0] last_q = '0, last_r = '0;
  logic         last_z = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc++;
    rst_at_edge = RST;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference results straight from the arithmetic definition of division.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    exp_t e;
`ifdef DIVIDER_SIGNED_EN
    int sa, sbv, qi, ri;
`endif
    e.k  = k;
    e.nz = (b != '0);
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.z = 1'b0;
`ifdef DIVIDER_SIGNED_EN
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      if (a == 16'h8000 && b == 16'hFFFF) begin
        e.q = 16'h8000;
        e.r = '0;
      end else begin
        qi  = sa / sbv;
        ri  = sa % sbv;
        e.q = qi[W-1:0];
        e.r = ri[W-1:0];
      end
`else
      e.q = a / b;
      e.r = a % b;
`endif
    end
    return e;
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    logic exp_busy;
    if (rst_at_edge) begin
      last_q = '0;
      last_r = '0;
      last_z = 1'b0;
    end
    if (mon_en) begin
      if (chk_busy) begin
        exp_busy = (sb.size() > 0) && sb[0].nz && (cyc >= sb[0].k) && (cyc <= sb[0].k + W - 1);
        check("busy", 32'(BUSY), 32'(exp_busy));
      end
      if (DONE) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got DONE=1, expected no DONE (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.k + (e.nz ? W : 0)));
          check("quotient", 32'(QUOTIENT), 32'(e.q));
          check("remainder", 32'(REMAINDER), 32'(e.r));
          check("div_by_zero", 32'(DIV_BY_ZERO), 32'(e.z));
          last_q = e.q;
          last_r = e.r;
          last_z = e.z;
        end
      end else begin
        check("held_q", 32'(QUOTIENT), 32'(last_q));
        check("held_r", 32'(REMAINDER), 32'(last_r));
        check("held_z", 32'(DIV_BY_ZERO), 32'(last_z));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((BUSY || DONE) && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: BUSY=%b DONE=%b still high, expected idle within 100 cycles", BUSY, DONE);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    START = 1'b1;
    DIVIDEND = a;
    DIVISOR = b;
    @(posedge CLK); #1;
    sb.push_back(model(a, b, cyc));
    START = 1'b0;
    DIVIDEND = W'($urandom);
    DIVISOR = W'($urandom);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_done"}, 32'(DONE), 32'd0);
    check({tag, "_q"}, 32'(QUOTIENT), 32'd0);
    check({tag, "_r"}, 32'(REMAINDER), 32'd0);
    check({tag, "_z"}, 32'(DIV_BY_ZERO), 32'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    int sel;
    RST = 1'b1;
    START = 1'b0;
    DIVIDEND = '0;
    DIVISOR = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_reset_state("reset");
    @(posedge CLK); #1;
    check_reset_state("idle");
    mon_en = 1'b1;

    issue(16'd100, 16'd7);
    issue(16'hFFFF, 16'd1);
    issue(16'd3, 16'd10);
    issue(16'd5, 16'd0);
    issue(16'd9, 16'd3);

    // Abort: second START lands mid-CALC, then reset discards the operation.
    wait_idle();
    chk_busy = 1'b0;
    START = 1'b1; DIVIDEND = 16'd200; DIVISOR = 16'd9;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    START = 1'b1; DIVIDEND = 16'd50; DIVISOR = 16'd5;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_reset_state("abort");
    @(posedge CLK); #1;
    chk_busy = 1'b1;
    issue(16'd200, 16'd9);

`ifdef DIVIDER_SIGNED_EN
    issue(16'hFF9C, 16'd7);
    issue(16'h8000, 16'hFFFF);
    issue(16'h0064, 16'hFFF9);
    issue(16'hFF9C, 16'hFFF9);
`endif

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = '0;
        1, 2, 3: b = W'($urandom_range(1, 15));
        4:       b = 16'hFFFF;
        5:       b = 16'h8000;
        6:       begin a = W'($urandom_range(0, 20)); b = W'($urandom_range(1, 40)); end
        default: b = W'($urandom);
      endcase
      issue(a, b);
    end

    wait_idle();
    repeat (2) @(posedge CLK);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
